core_test_monitor: RTL and testbench
====================================

Name: core_test_monitor

Overview:
Synthesisable, parametrised successor to the fixed-stimulus core bench. It sequences the core's reset, counts run cycles and watches the core's result bus. It declares pass when the bus settles on an expected value, and fail on timeout. It sits beside the core, in simulation top-levels and FPGA bring-up, and drives the core reset and a pass/fail/done status.

Parameters:
OUT_W, 10, width of the core result bus
EXPECTED, 10'd45, value that constitutes a pass (sum 1..9 test program)
RST_CYCLES, 5, cycles core_reset is held high after start (min 1)
STABLE_CYCLES, 4, consecutive equal samples required to call the bus settled (min 1)
TIMEOUT, 200, max RUN cycles before fail (min STABLE_CYCLES)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  single-cycle request to begin a test run
core_out  in  OUT_W  core result bus being monitored
core_reset  out  1  active-high reset driven to the core
busy  out  1  high in RESET_CORE and RUN
done  out  1  high in DONE
pass  out  1  valid when done
fail  out  1  valid when done
cycle_count  out  CNT_W  RUN cycles elapsed; frozen in DONE
final_value  out  OUT_W  core_out sampled at the terminating cycle

Behaviour:
- Reset (reset=0, async): state=IDLE, core_reset=1, busy=0, done=0, pass=0, fail=0, cycle_count=0, final_value=0, internal counters=0.
- IDLE: core_reset=1. On start=1, go to RESET_CORE, clear cycle_count, pass, fail and final_value.
- RESET_CORE: core_reset=1 for exactly RST_CYCLES cycles (rst counter 0..RST_CYCLES-1), then go to RUN. core_reset falls on the edge that enters RUN.
- RUN: core_reset=0. cycle_count increments every cycle, saturating at TIMEOUT.
  - Stability counter: if core_out == previous sample, increment, saturating at STABLE_CYCLES. Otherwise clear to 0. The first RUN cycle clears it and loads the previous-sample register.
  - Settled = stability counter reaches STABLE_CYCLES-1 this cycle with an equal sample.
  - Settled and core_out==EXPECTED: next state DONE, pass=1, final_value=core_out.
  - cycle_count==TIMEOUT-1 and not passing: next state DONE, fail=1, final_value=core_out.
  - Pass and timeout in the same cycle: pass wins.
- DONE: done=1, core_reset stays 0 (core keeps running for waveform inspection), outputs frozen.
  - start=1 restarts, going to RESET_CORE with the same clearing as from IDLE.
- start while busy: ignored, no effect.
- pass and fail are never both 1. Both are 0 whenever done=0.
- Async reset mid-run: immediate return to reset values. core_reset reasserts asynchronously.
- CNT_W = $clog2(TIMEOUT+1). Counter comparisons are unsigned. No wrap: cycle_count saturates.
- Latency: pass asserted at the earliest STABLE_CYCLES cycles after the first RUN cycle carrying EXPECTED.

Optional Feature:
- Macro CORE_MON_EARLY_FAIL_EN.
- With it defined: settled on a value != EXPECTED ends the run at once, going to DONE with fail=1 and final_value = that value. The run does not wait for TIMEOUT.
- Without it: a settled wrong value is ignored. The bus may later change to EXPECTED and pass; otherwise the run fails at TIMEOUT.

Decomposition:
- Package core_mon_pkg:
  - state enum {IDLE, RESET_CORE, RUN, DONE} (2-bit)
  - cnt_w function computing $clog2(n+1)
- Sub-module core_mon_stable_det:
  - Contents: previous-sample register, saturating equality counter, settled output.
  - Parameters: OUT_W, STABLE_CYCLES.
  - Inputs: clk, reset, clear, sample.
- The top holds the FSM, the reset and cycle counters, and the result registers.

Test Plan:
- Reset check: hold reset=0 with random core_out -> core_reset=1, busy=done=pass=fail=0, cycle_count=0.
- Reset sequencing: start pulse -> core_reset high exactly 5 cycles. Then core_out ramps 0,1,3,...,45 and holds 45 -> pass=1, fail=0, final_value=45, done 4 cycles after 45 first appears.
- Timeout: core_out toggles 0/1 every cycle -> done with fail=1 at cycle_count=200, final_value = last sample.
- Wrong settled value 44 held from RUN cycle 10:
  - macro defined -> fail at cycle_count 13.
  - macro undefined -> fail only at 200.
- Boundaries:
  - 45 settles exactly on cycle 199 -> pass (not fail).
  - start pulses during RUN -> ignored.
  - start in DONE -> clean restart with cleared status.
- Reset mid-run: reset=0 at RUN cycle 50 -> all outputs return to reset values asynchronously. The next start run behaves identically to the first.

Source files
------------

// File: rtl/core_mon_pkg.sv
// rtl/core_mon_pkg.sv - shared state encoding and width helper for the core test monitor
package core_mon_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_CORE = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } state_e;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/core_mon_stable_det.sv
// rtl/core_mon_stable_det.sv - flags when the monitored bus has held one value for STABLE_CYCLES samples
module core_mon_stable_det
    import core_mon_pkg::*;
#(
    parameter int OUT_W         = 10,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [OUT_W-1:0] sample,
    output logic             settled
);

    localparam int SW = cnt_w(STABLE_CYCLES);

    logic [OUT_W-1:0] prev;
    logic [SW-1:0]    cnt;
    logic             equal;

    assign equal = (sample == prev);

    // cnt counts equal comparisons already seen, so this sample completes the run when cnt+1 reaches STABLE_CYCLES-1
    assign settled = !clear && equal && ((int'(cnt) + 1) >= (STABLE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= '0;
            cnt  <= '0;
        end else begin
            prev <= sample;
            if (clear || !equal) begin
                cnt <= '0;
            end else if (cnt != SW'(STABLE_CYCLES)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_test_monitor.sv
// rtl/core_test_monitor.sv - sequences core reset, times the run and reports pass/fail; CORE_MON_EARLY_FAIL_EN ends a run on a settled wrong value
module core_test_monitor
    import core_mon_pkg::*;
#(
    parameter int               OUT_W         = 10,
    parameter logic [OUT_W-1:0] EXPECTED      = OUT_W'(45),
    parameter int               RST_CYCLES    = 5,
    parameter int               STABLE_CYCLES = 4,
    parameter int               TIMEOUT       = 200,
    localparam int              CNT_W         = cnt_w(TIMEOUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OUT_W-1:0] core_out,
    output logic             core_reset,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] cycle_count,
    output logic [OUT_W-1:0] final_value
);

    localparam int RW = cnt_w(RST_CYCLES);

    state_e          state;
    logic [RW-1:0]   rst_cnt;
    logic            det_clear;
    logic            settled;
    logic            is_pass;
    logic            early_fail;

    // Decoded from state so an async reset pulls core_reset high immediately
    assign core_reset = (state == IDLE) || (state == RESET_CORE);
    assign busy       = (state == RESET_CORE) || (state == RUN);
    assign done       = (state == DONE);

    assign det_clear  = (state != RUN) || (cycle_count == '0);
    assign is_pass    = settled && (core_out == EXPECTED);

`ifdef CORE_MON_EARLY_FAIL_EN
    assign early_fail = settled && (core_out != EXPECTED);
`else
    assign early_fail = 1'b0;
`endif

    core_mon_stable_det #(
        .OUT_W         (OUT_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stable_det (
        .clk     (clk),
        .reset   (reset),
        .clear   (det_clear),
        .sample  (core_out),
        .settled (settled)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            final_value <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RESET_CORE;
                        rst_cnt     <= '0;
                        cycle_count <= '0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        final_value <= '0;
                    end
                end
                RESET_CORE: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        state   <= RUN;
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (cycle_count != CNT_W'(TIMEOUT)) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    // Pass is tested first so a settle on the last allowed cycle beats the timeout
                    if (is_pass) begin
                        state       <= DONE;
                        pass        <= 1'b1;
                        final_value <= core_out;
                    end else if (early_fail || (cycle_count == CNT_W'(TIMEOUT - 1))) begin
                        state       <= DONE;
                        fail        <= 1'b1;
                        final_value <= core_out;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_test_monitor.sv
// tb/tb_core_test_monitor.sv - randomized self-checking bench for core_test_monitor
module tb_core_test_monitor;

    localparam int OUT_W         = 10;
    localparam int EXPECTED      = 45;
    localparam int RST_CYCLES    = 5;
    localparam int STABLE_CYCLES = 4;
    localparam int TIMEOUT       = 200;
    localparam int CNT_W         = $clog2(TIMEOUT + 1);
`ifdef CORE_MON_EARLY_FAIL_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [OUT_W-1:0] core_out = '0;
    logic             core_reset;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [CNT_W-1:0] cycle_count;
    logic [OUT_W-1:0] final_value;

    always #5 clk = ~clk;

    core_test_monitor #(
        .OUT_W         (OUT_W),
        .EXPECTED      (OUT_W'(EXPECTED)),
        .RST_CYCLES    (RST_CYCLES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core_out    (core_out),
        .core_reset  (core_reset),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .cycle_count (cycle_count),
        .final_value (final_value)
    );

    int checks = 0;
    int failures = 0;
    int seq[0:255];
    bit exp_pass;
    bit exp_fail;
    int exp_cc;
    int exp_final;
    int rc;
    int k;
    bit timed_out;

    // Reference: a run ends at the first RUN cycle where the last STABLE_CYCLES samples are equal
    // (and equal to EXPECTED, or any value with early fail), or at the TIMEOUT-th cycle.
    function automatic void model();
        int run = 0;
        exp_pass = 1'b0;
        exp_fail = 1'b0;
        exp_cc = TIMEOUT;
        exp_final = seq[TIMEOUT-1];
        for (int c = 0; c < TIMEOUT; c++) begin
            run = (c > 0 && seq[c] == seq[c-1]) ? run + 1 : 1;
            if (run >= STABLE_CYCLES && seq[c] == EXPECTED) begin
                exp_pass = 1'b1; exp_cc = c + 1; exp_final = seq[c];
                return;
            end
            if ((run >= STABLE_CYCLES && EARLY) || c == TIMEOUT - 1) begin
                exp_fail = 1'b1; exp_cc = c + 1; exp_final = seq[c];
                return;
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives seq[k] during RUN cycle k; counts RESET_CORE cycles; stops at done, abort_at, or guard expiry
    task automatic drive_run(input bit noisy, input int abort_at);
        int guard = 0;
        rc = 0;
        k = 0;
        timed_out = 1'b0;
        while (!done) begin
            if (guard >= 600) begin
                timed_out = 1'b1;
                break;
            end
            start = 1'b0;
            if (busy && core_reset) rc++;
            if (busy && !core_reset) begin
                if (k == abort_at) return;
                core_out = OUT_W'(seq[k]);
                k++;
                if (noisy) start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            core_out = OUT_W'($urandom_range(0, 1023));
        end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
        checks++; if ({busy, done, pass, fail} !== 4'b0000) begin failures++; $display("FAIL reset_status: got busy/done/pass/fail=%b want 0000", {busy, done, pass, fail}); end
        checks++; if (cycle_count !== '0) begin failures++; $display("FAIL reset_cycle_count: got %0d want 0", cycle_count); end
        checks++; if (final_value !== '0) begin failures++; $display("FAIL reset_final_value: got %0d want 0", final_value); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (core_reset !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset: got core_reset=%b busy=%b want 1 0", core_reset, busy); end
    endtask

    task automatic test_sequencing();
        for (int i = 0; i < 256; i++) seq[i] = (i <= 9) ? i * (i + 1) / 2 : EXPECTED;
        model();
        pulse_start();
        drive_run(1'b0, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL seq_done_timeout: got no done want done"); end
        checks++; if (rc !== RST_CYCLES) begin failures++; $display("FAIL seq_rst_cycles: got %0d want %0d", rc, RST_CYCLES); end
        checks++; if (pass !== 1'b1 || fail !== 1'b0) begin failures++; $display("FAIL seq_verdict: got pass=%b fail=%b want 1 0", pass, fail); end
        checks++; if (final_value !== OUT_W'(EXPECTED)) begin failures++; $display("FAIL seq_final_value: got %0d want %0d", final_value, EXPECTED); end
        checks++; if (cycle_count !== CNT_W'(9 + STABLE_CYCLES)) begin failures++; $display("FAIL seq_latency: got %0d want %0d", cycle_count, 9 + STABLE_CYCLES); end
        checks++; if (cycle_count !== CNT_W'(exp_cc)) begin failures++; $display("FAIL seq_model_cc: got %0d want %0d", cycle_count, exp_cc); end
    endtask

    task automatic test_timeout();
        logic [CNT_W-1:0] cc_hold;
        logic [OUT_W-1:0] fv_hold;
        for (int i = 0; i < 256; i++) seq[i] = i % 2;
        model();
        pulse_start();
        drive_run(1'b0, -1);
        checks++; if (fail !== 1'b1 || pass !== 1'b0) begin failures++; $display("FAIL timeout_verdict: got pass=%b fail=%b want 0 1", pass, fail); end
        checks++; if (cycle_count !== CNT_W'(TIMEOUT)) begin failures++; $display("FAIL timeout_cc: got %0d want %0d", cycle_count, TIMEOUT); end
        checks++; if (final_value !== OUT_W'(seq[TIMEOUT-1])) begin failures++; $display("FAIL timeout_final: got %0d want %0d", final_value, seq[TIMEOUT-1]); end
        cc_hold = cycle_count;
        fv_hold = final_value;
        repeat (4) begin
            core_out = OUT_W'($urandom_range(0, 1023));
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || core_reset !== 1'b0) begin failures++; $display("FAIL done_hold: got done=%b core_reset=%b want 1 0", done, core_reset); end
        checks++; if (cycle_count !== cc_hold || final_value !== fv_hold) begin failures++; $display("FAIL done_frozen: got cc=%0d fv=%0d want %0d %0d", cycle_count, final_value, cc_hold, fv_hold); end
    endtask

    task automatic test_wrong_settle();
        for (int i = 0; i < 256; i++) seq[i] = (i < 9) ? 100 + i : 44;
        model();
        pulse_start();
        drive_run(1'b0, -1);
        checks++; if (fail !== 1'b1 || pass !== 1'b0) begin failures++; $display("FAIL wrong_verdict: got pass=%b fail=%b want 0 1", pass, fail); end
        checks++; if (cycle_count !== CNT_W'(EARLY ? 13 : TIMEOUT)) begin failures++; $display("FAIL wrong_cc: got %0d want %0d", cycle_count, EARLY ? 13 : TIMEOUT); end
        checks++; if (final_value !== OUT_W'(44)) begin failures++; $display("FAIL wrong_final: got %0d want 44", final_value); end
    endtask

    task automatic test_late_pass();
        for (int i = 0; i < 256; i++) seq[i] = (i < TIMEOUT - STABLE_CYCLES) ? i % 2 : EXPECTED;
        model();
        pulse_start();
        drive_run(1'b0, -1);
        checks++; if (pass !== 1'b1 || fail !== 1'b0) begin failures++; $display("FAIL late_verdict: got pass=%b fail=%b want 1 0", pass, fail); end
        checks++; if (cycle_count !== CNT_W'(TIMEOUT)) begin failures++; $display("FAIL late_cc: got %0d want %0d", cycle_count, TIMEOUT); end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 256; i++) seq[i] = (i < 20) ? $urandom_range(0, 40) * 2 + i % 2 : EXPECTED;
        model();
        pulse_start();
        drive_run(1'b1, -1);
        checks++; if (rc !== RST_CYCLES) begin failures++; $display("FAIL noisy_rst_cycles: got %0d want %0d", rc, RST_CYCLES); end
        checks++; if (pass !== exp_pass || fail !== exp_fail) begin failures++; $display("FAIL noisy_verdict: got pass=%b fail=%b want %b %b", pass, fail, exp_pass, exp_fail); end
        checks++; if (cycle_count !== CNT_W'(exp_cc) || final_value !== OUT_W'(exp_final)) begin failures++; $display("FAIL noisy_result: got cc=%0d fv=%0d want %0d %0d", cycle_count, final_value, exp_cc, exp_final); end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 256; i++) seq[i] = $urandom_range(0, 1) ? 7 : 8;
        model();
        pulse_start();
        checks++; if ({done, busy, core_reset} !== 3'b011) begin failures++; $display("FAIL restart_state: got done/busy/core_reset=%b want 011", {done, busy, core_reset}); end
        checks++; if ({pass, fail} !== 2'b00 || cycle_count !== '0 || final_value !== '0) begin failures++; $display("FAIL restart_clear: got pass=%b fail=%b cc=%0d fv=%0d want 0 0 0 0", pass, fail, cycle_count, final_value); end
        drive_run(1'b0, -1);
        checks++; if (pass !== exp_pass || fail !== exp_fail || cycle_count !== CNT_W'(exp_cc)) begin failures++; $display("FAIL restart_result: got pass=%b fail=%b cc=%0d want %b %b %0d", pass, fail, cycle_count, exp_pass, exp_fail, exp_cc); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int i = 0;
            while (i < 256) begin
                int sel = $urandom_range(0, 3);
                int v = (sel == 0) ? EXPECTED : (sel == 1) ? 44 : $urandom_range(0, 1023);
                int len = $urandom_range(1, 6);
                for (int j = 0; j < len && i < 256; j++) begin
                    seq[i] = v;
                    i++;
                end
            end
            model();
            pulse_start();
            drive_run(1'b0, -1);
            checks++; if (pass !== exp_pass || fail !== exp_fail) begin failures++; $display("FAIL rand%0d_verdict: got pass=%b fail=%b want %b %b", r, pass, fail, exp_pass, exp_fail); end
            checks++; if (cycle_count !== CNT_W'(exp_cc) || final_value !== OUT_W'(exp_final)) begin failures++; $display("FAIL rand%0d_result: got cc=%0d fv=%0d want %0d %0d", r, cycle_count, final_value, exp_cc, exp_final); end
        end
    endtask

    task automatic test_reset_mid_run();
        int first_rc;
        for (int i = 0; i < 256; i++) seq[i] = (i < 120) ? (i % 3) : EXPECTED;
        model();
        pulse_start();
        drive_run(1'b0, 50);
        checks++; if (cycle_count !== CNT_W'(50)) begin failures++; $display("FAIL mid_cc_before: got %0d want 50", cycle_count); end
        first_rc = rc;
        #2 reset = 1'b0;
        #1;
        checks++; if (core_reset !== 1'b1 || {busy, done, pass, fail} !== 4'b0000) begin failures++; $display("FAIL mid_async_status: got core_reset=%b busy/done/pass/fail=%b want 1 0000", core_reset, {busy, done, pass, fail}); end
        checks++; if (cycle_count !== '0 || final_value !== '0) begin failures++; $display("FAIL mid_async_regs: got cc=%0d fv=%0d want 0 0", cycle_count, final_value); end
        @(negedge clk);
        reset = 1'b1;
        pulse_start();
        drive_run(1'b0, -1);
        checks++; if (rc !== first_rc || rc !== RST_CYCLES) begin failures++; $display("FAIL mid_rerun_rst: got %0d want %0d", rc, RST_CYCLES); end
        checks++; if (pass !== exp_pass || fail !== exp_fail || cycle_count !== CNT_W'(exp_cc) || final_value !== OUT_W'(exp_final)) begin failures++; $display("FAIL mid_rerun_result: got pass=%b fail=%b cc=%0d fv=%0d want %b %b %0d %0d", pass, fail, cycle_count, final_value, exp_pass, exp_fail, exp_cc, exp_final); end
    endtask

    initial begin
        test_reset();
        test_sequencing();
        test_timeout();
        test_wrong_settle();
        test_late_pass();
        test_start_ignored();
        test_restart();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
